// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_arbiter
// Purpose  : Round-robin scheduler sharing one uart_tx serializer among NREQ
//            byte producers, with a watchdog on the transmit-done handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DBIT        = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*DBIT-1:0] i_data,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_tx_start,
  output logic [DBIT-1:0]      o_tx_data,
  input  logic                 i_tx_done_tick,
  output logic                 o_busy,
  output logic [2:0]           o_owner,
  output logic                 o_timeout
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic [DBIT-1:0]   r_tx_data, w_tx_data_nxt;
  logic              r_busy, w_busy_nxt;
  logic [2:0]        r_owner, w_owner_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [WD_W-1:0]   r_wdog, w_wdog_nxt;

  logic              w_found;
  logic [2:0]        w_sel;
  int                w_dist;
  int                w_best_dist;

  // Priority distance of requester k is how far it sits after the last owner.
  always_comb begin
    w_found     = 1'b0;
    w_sel       = 3'd0;
    w_best_dist = NREQ;
    w_dist      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_dist = (k + NREQ - 1 - int'(r_owner)) % NREQ;
      if (i_req[k] && (w_dist < w_best_dist)) begin
        w_found     = 1'b1;
        w_best_dist = w_dist;
        w_sel       = 3'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = '0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_owner_nxt    = r_owner;
    w_timeout_nxt  = 1'b0;
    w_wdog_nxt     = r_wdog;
    case (r_state)
      S_IDLE: begin
        w_wdog_nxt = '0;
        if (w_found) begin
          w_grant_nxt   = NREQ'(1) << w_sel;
          w_tx_data_nxt = i_data[int'(w_sel)*DBIT +: DBIT];
          w_owner_nxt   = w_sel;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        w_tx_start_nxt = 1'b1;
        w_wdog_nxt     = '0;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // A done tick on the last watchdog cycle still counts as success.
        if (i_tx_done_tick) begin
          w_wdog_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
          w_timeout_nxt = 1'b1;
          w_wdog_nxt    = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end
      default: begin
        w_wdog_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_owner    <= 3'(NREQ - 1);
      r_timeout  <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= w_busy_nxt;
      r_owner    <= w_owner_nxt;
      r_timeout  <= w_timeout_nxt;
      r_wdog     <= w_wdog_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_owner    = r_owner;
  assign o_timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed plus randomized checks of uart_tx_arbiter against a
//            transaction-level round-robin model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int TCYC = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      i_req;
  logic [NREQ*DBIT-1:0] i_data;
  logic [NREQ-1:0]      o_grant;
  logic                 o_tx_start;
  logic [DBIT-1:0]      o_tx_data;
  logic                 done;
  logic                 o_busy;
  logic [2:0]           o_owner;
  logic                 o_timeout;

  int total = 0;
  int bad   = 0;
  int m_owner;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TIMEOUT_CYC(TCYC)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_req          (i_req),
    .i_data         (i_data),
    .o_grant        (o_grant),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_done_tick (done),
    .o_busy         (o_busy),
    .o_owner        (o_owner),
    .o_timeout      (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next owner: first requesting index after the current owner, modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] req, input int owner);
    for (int s = 1; s <= NREQ; s++)
      if (req[(owner + s) % NREQ]) return (owner + s) % NREQ;
    return -1;
  endfunction

  // One complete transfer starting from IDLE. d = cycles after the start pulse
  // until done is sampled (1..TCYC); with to=1 no done is given and the
  // watchdog must fire exactly TCYC cycles after the start pulse.
  task automatic transfer(input logic [NREQ-1:0] req, input logic [31:0] data,
                          input int d, input bit to, input bit keep, input bit glitch);
    int k;
    logic [7:0] b;
    i_req  = req;
    i_data = data;
    k = pick(req, m_owner);
    b = data[k*8 +: 8];
    tick();
    chk("grant", o_grant, 32'(1) << k);
    chk("owner", o_owner, k);
    chk("busy_start", o_busy, 1);
    chk("start_early", o_tx_start, 0);
    chk("timeout_pulse", o_timeout, 0);
    m_owner = k;
    if (!keep) i_req = req & ~(4'b0001 << k);
    if (glitch) done = 1'b1;
    tick();
    done = 1'b0;
    chk("tx_start", o_tx_start, 1);
    chk("tx_data", o_tx_data, b);
    chk("grant_pulse", o_grant, 0);
    for (int c = 1; c <= d; c++) begin
      if (c == d && !to) done = 1'b1;
      tick();
      done = 1'b0;
      if (c < d) begin
        chk("tx_start_hold", o_tx_start, 0);
        chk("busy_wait", o_busy, 1);
        chk("timeout_early", o_timeout, 0);
        chk("tx_data_stable", o_tx_data, b);
      end
    end
    chk("busy_end", o_busy, 0);
    chk("timeout", o_timeout, to);
    chk("owner_end", o_owner, m_owner);
  endtask

  task automatic idle_step(input bit spurious);
    i_req = '0;
    done  = spurious;
    tick();
    done  = 1'b0;
    chk("idle_grant", o_grant, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_start", o_tx_start, 0);
    chk("idle_owner", o_owner, m_owner);
  endtask

  initial begin
    int rq, dl;
    bit to;
    i_req  = '0;
    i_data = '0;
    done   = 1'b0;
    rst_n  = 1'b1;
    m_owner = NREQ - 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", o_grant, 0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_data", o_tx_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_owner", o_owner, NREQ - 1);
    chk("rst_timeout", o_timeout, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset mid-transfer, asynchronously, while the start pulse is high.
    i_req  = 4'b0010;
    i_data = 32'h0000_5A00;
    tick();
    chk("pre_rst_grant", o_grant, 4'b0010);
    tick();
    chk("pre_rst_start", o_tx_start, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", o_tx_start, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_owner", o_owner, NREQ - 1);
    #2 rst_n = 1'b1;
    m_owner = NREQ - 1;
    transfer(4'b0001, 32'h0000_00C3, 3, 1'b0, 1'b0, 1'b0);

    // Single requester.
    transfer(4'b0100, 32'h00A5_0000, 4, 1'b0, 1'b0, 1'b0);

    // Round robin with all requests held.
    for (int i = 0; i < 5; i++)
      transfer(4'b1111, 32'h4433_2211, 2, 1'b0, 1'b1, 1'b0);

    // Pointer wrap.
    transfer(4'b1000, 32'h7700_0000, 1, 1'b0, 1'b0, 1'b0);
    transfer(4'b1001, 32'h8800_0066, 2, 1'b0, 1'b1, 1'b0);
    transfer(4'b1001, 32'h8800_0066, 2, 1'b0, 1'b1, 1'b0);
    transfer(4'b1001, 32'h8800_0066, 2, 1'b0, 1'b1, 1'b0);

    // Watchdog, then normal service, then done colliding with the last cycle.
    transfer(4'b0010, 32'h0000_EE00, TCYC, 1'b1, 1'b0, 1'b0);
    transfer(4'b0100, 32'h0012_0000, 2, 1'b0, 1'b0, 1'b0);
    transfer(4'b0001, 32'h0000_0034, TCYC, 1'b0, 1'b0, 1'b0);

    // Spurious done ticks in IDLE and in START.
    idle_step(1'b1);
    idle_step(1'b0);
    transfer(4'b1000, 32'h9900_0000, 3, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rq = $urandom_range(0, 15);
      if (rq == 0) begin
        idle_step(1'($urandom_range(0, 1)));
      end else begin
        to = ($urandom_range(0, 4) == 0);
        dl = to ? TCYC : $urandom_range(1, TCYC);
        transfer(4'(rq), $urandom, dl, to, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
